// File: rtl/d_port_master_pkg.sv
// d_port_master_pkg: direction, op and state encodings shared by the data-memory port master
package d_port_master_pkg;
   localparam logic DIRECTION_READ  = 1'b0;
   localparam logic DIRECTION_WRITE = 1'b1;
   typedef enum logic [1:0] {
      D_OP_READ  = 2'd0,
      D_OP_WRITE = 2'd1,
      D_OP_ADD   = 2'd2,
      D_OP_RSVD  = 2'd3
   } d_op_e;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_GAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction
endpackage

// File: rtl/d_port_master.sv
// d_port_master: data-memory port initiator running READ, WRITE and ADD (read-modify-write) with ack timeout
module d_port_master
   import d_port_master_pkg::*;
#(
   parameter int d_addr_width = 8,
   parameter int ack_timeout  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [d_addr_width-1:0] cmd_addr,
   input  logic [7:0]              cmd_wdata,
   output logic                    rsp_valid,
   output logic [7:0]              rsp_data,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    d_req,
   output logic                    d_dir,
   output logic [d_addr_width-1:0] d_addr,
   output logic [7:0]              d_wdata,
   input  logic                    d_ack,
   input  logic [7:0]              d_rdata
);
   localparam int cw = ack_timeout > 1 ? $clog2(ack_timeout + 1) : 1;
   localparam logic [cw-1:0] cnt_last = cw'(ack_timeout > 0 ? ack_timeout - 1 : 0);
   logic [2:0]    state, state_n;
   logic          req_q, is_add, in_xfer, ack_ok, tmo;
   logic [7:0]    delta;
   logic [cw-1:0] cnt;
   assign in_xfer = state == S_RD || state == S_WR;
   // an ack only counts once req has been high for a full cycle, so a lingering ack is never taken as new
   assign ack_ok  = in_xfer && d_ack && req_q;
   assign tmo     = (ack_timeout != 0) && in_xfer && !ack_ok && cnt == cnt_last;
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = cmd_valid ? (cmd_op == D_OP_WRITE ? S_WR : S_RD) : S_IDLE;
         S_RD:    state_n = tmo ? S_DONE : ack_ok ? (is_add ? S_GAP : S_DONE) : S_RD;
         S_GAP:   state_n = S_WR;
         S_WR:    state_n = (tmo || ack_ok) ? S_DONE : S_WR;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         req_q     <= 1'b0;
         is_add    <= 1'b0;
         delta     <= '0;
         cnt       <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         d_req     <= 1'b0;
         d_dir     <= DIRECTION_READ;
         d_addr    <= '0;
         d_wdata   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         req_q     <= d_req;
         cmd_ready <= state_n == S_IDLE;
         busy      <= state_n != S_IDLE;
         d_req     <= state_n == S_RD || state_n == S_WR;
         d_dir     <= state_n == S_WR ? DIRECTION_WRITE : DIRECTION_READ;
         cnt       <= (in_xfer && state_n == state) ? cnt + 1'b1 : '0;
         rsp_valid <= state_n == S_DONE;
         rsp_err   <= tmo;
         if (state == S_IDLE && cmd_valid) begin
            is_add <= cmd_op == D_OP_ADD;
            delta  <= cmd_wdata;
            d_addr <= cmd_addr;
            if (cmd_op == D_OP_WRITE) d_wdata <= cmd_wdata;
         end
         if (state == S_RD && ack_ok && is_add) d_wdata <= add8(d_rdata, delta);
         if (state_n == S_DONE) rsp_data <= tmo ? '0 : state == S_RD ? d_rdata : d_wdata;
      end
   end
endmodule

// File: tb/tb_d_port_master.sv
// tb_d_port_master: randomized checks of d_port_master against a memory-level command model
module tb_d_port_master;
   import d_port_master_pkg::*;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rst, cmd_valid, cmd_ready, rsp_valid, rsp_err, busy, d_req, d_dir, d_ack;
   logic [1:0] cmd_op;
   logic [7:0] cmd_addr, cmd_wdata, rsp_data, d_addr, d_wdata, d_rdata;
   logic       nt_cmd_valid, nt_cmd_ready, nt_rsp_valid, nt_rsp_err, nt_busy, nt_d_req, nt_d_dir;
   logic [1:0] nt_cmd_op;
   logic [7:0] nt_cmd_addr, nt_cmd_wdata, nt_rsp_data, nt_d_addr, nt_d_wdata, nt_d_rdata;
   logic       nt_d_ack;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   int         ack_dly, acnt;
   logic       no_ack, mem_init;
   int         vec = 0, bad = 0;
   int         stab_err = 0, pulse_err = 0, rdy_err = 0, gap_err = 0;
   int         rsp_cnt = 0, wr_cnt = 0, nt_rsp_cnt = 0;
   logic       p_req = 1'b0, p_rv = 1'b0;
   logic [16:0] p_bus = '0;
   logic [31:0] last_tr;

   d_port_master #(.d_addr_width(8), .ack_timeout(16)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy), .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata));

   d_port_master #(.d_addr_width(8), .ack_timeout(0)) u_dut_nt (
      .clk(clk), .rst(rst), .cmd_valid(nt_cmd_valid), .cmd_ready(nt_cmd_ready), .cmd_op(nt_cmd_op),
      .cmd_addr(nt_cmd_addr), .cmd_wdata(nt_cmd_wdata), .rsp_valid(nt_rsp_valid), .rsp_data(nt_rsp_data),
      .rsp_err(nt_rsp_err), .busy(nt_busy), .d_req(nt_d_req), .d_dir(nt_d_dir), .d_addr(nt_d_addr),
      .d_wdata(nt_d_wdata), .d_ack(nt_d_ack), .d_rdata(nt_d_rdata));

   assign d_rdata    = mem[d_addr];
   assign nt_d_ack   = 1'b0;
   assign nt_d_rdata = 8'h00;

   // responder: ack ack_dly cycles after req is seen, held while req stays high; write lands when ack rises
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7);
         d_ack <= 1'b0;
         acnt  <= 0;
      end else if (!d_req || no_ack) begin
         d_ack <= 1'b0;
         acnt  <= 0;
      end else if (!d_ack) begin
         if (acnt >= ack_dly) begin
            d_ack <= 1'b1;
            if (d_dir == DIRECTION_WRITE) mem[d_addr] <= d_wdata;
         end else acnt <= acnt + 1;
      end
   end

   always @(negedge clk) begin
      p_req <= d_req;
      p_rv  <= rsp_valid;
      p_bus <= {d_addr, d_dir, d_wdata};
      if (d_req && p_req && {d_addr, d_dir, d_wdata} != p_bus) stab_err <= stab_err + 1;
      if (rsp_valid && p_rv) pulse_err <= pulse_err + 1;
      if (cmd_ready == busy || (cmd_ready && d_req)) rdy_err <= rdy_err + 1;
      if ((rsp_valid || p_rv) && d_req) gap_err <= gap_err + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (d_req && !p_req && d_dir == DIRECTION_WRITE) wr_cnt <= wr_cnt + 1;
      if (nt_rsp_valid) nt_rsp_cnt <= nt_rsp_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic er, output int lat, output logic [31:0] tr);
      int w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) check("ready_wait", 32'(w), 0);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = d;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat = 0;
      tr  = '0;
      rd  = '0;
      er  = 1'b1;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat < 32) tr[lat] = d_req;
         if (rsp_valid) begin
            rd = rsp_data;
            er = rsp_err;
            break;
         end
      end
      if (lat >= 200) check("rsp_wait", 32'(lat), 0);
   endtask

   // model: each transaction costs (3 + ack delay) cycles; ADD is two transactions
   task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d, input int dly);
      logic [7:0]  exp, rd;
      logic        er;
      int          lat;
      logic [31:0] tr;
      ack_dly = dly;
      if (op == D_OP_WRITE) begin
         ref_mem[a] = d;
         exp = d;
      end else if (op == D_OP_ADD) begin
         ref_mem[a] = ref_mem[a] + d;
         exp = ref_mem[a];
      end else exp = ref_mem[a];
      run_cmd(op, a, d, rd, er, lat, tr);
      check($sformatf("rsp_data op%0d @%0h", op, a), 32'(rd), 32'(exp));
      check($sformatf("rsp_err op%0d @%0h", op, a), 32'(er), 0);
      check($sformatf("latency op%0d dly%0d", op, dly), 32'(lat), 32'((op == D_OP_ADD ? 2 : 1) * (3 + dly)));
      last_tr = tr;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  rd;
      logic        er;
      int          lat, wb, rb, w, diff;
      logic [31:0] tr;
      rst = 1'b1; mem_init = 1'b1; no_ack = 1'b0; ack_dly = 0;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
      nt_cmd_valid = 1'b0; nt_cmd_op = 2'd0; nt_cmd_addr = 8'h00; nt_cmd_wdata = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", 32'({d_req, d_dir, rsp_valid, rsp_err, cmd_ready, busy}), 32'(6'b000010));
      check("reset_bus", 32'({d_addr, d_wdata, rsp_data}), 0);
      mem_init = 1'b0;
      rst = 1'b0;

      do_cmd(D_OP_WRITE, 8'h05, 8'h3C, 0);
      do_cmd(D_OP_READ, 8'h05, 8'h00, 0);

      do_cmd(D_OP_WRITE, 8'h10, 8'hFF, 0);
      do_cmd(D_OP_ADD, 8'h10, 8'h01, 0);
      check("add_req_pattern", 32'(last_tr[6:1]), 32'(6'b011011));
      check("mem_after_wrap", 32'(mem[8'h10]), 0);
      do_cmd(D_OP_ADD, 8'h10, 8'hFF, 0);

      ack_dly = 0;
      cmd_op  = D_OP_READ;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         @(negedge clk);
         while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
         end
         cmd_valid = 1'b1;
         cmd_addr  = 8'(i);
         w = 0;
         @(negedge clk);
         while (!rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
         end
         check($sformatf("b2b_data @%0d", i), 32'(rsp_data), 32'(ref_mem[i]));
      end
      cmd_valid = 1'b0;

      do_cmd(D_OP_WRITE, 8'h30, 8'hA5, 5);
      do_cmd(D_OP_READ, 8'h30, 8'h00, 5);
      do_cmd(D_OP_ADD, 8'h30, 8'h10, 5);

      no_ack = 1'b1;
      @(negedge clk);
      nt_cmd_valid = 1'b1;
      nt_cmd_addr  = 8'h07;
      @(posedge clk);
      #1 nt_cmd_valid = 1'b0;
      run_cmd(D_OP_READ, 8'h05, 8'h00, rd, er, lat, tr);
      check("tmo_read_err", 32'(er), 1);
      check("tmo_read_data", 32'(rd), 0);
      check("tmo_read_lat", 32'(lat), 17);
      check("tmo_req_cycles", 32'($countones(tr)), 16);
      wb = wr_cnt;
      run_cmd(D_OP_ADD, 8'h05, 8'h01, rd, er, lat, tr);
      check("tmo_add_err", 32'(er), 1);
      check("tmo_add_lat", 32'(lat), 17);
      check("tmo_add_no_write", 32'(wr_cnt), 32'(wb));
      no_ack = 1'b0;
      check("nt_waiting", 32'({nt_busy, nt_d_req, nt_cmd_ready, nt_d_dir}), 32'(4'b1100));
      check("nt_addr", 32'(nt_d_addr), 32'h07);
      check("nt_no_rsp", 32'(nt_rsp_cnt), 0);
      check("nt_outputs", 32'({nt_rsp_data, nt_rsp_err, nt_d_wdata}), 0);

      do_cmd(D_OP_WRITE, 8'h20, 8'h40, 5);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = D_OP_ADD; cmd_addr = 8'h20; cmd_wdata = 8'h01;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      w = 0;
      @(negedge clk);
      while (!(d_req && d_dir == DIRECTION_WRITE) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("reach_wr", 32'(w < 100), 1);
      rb = rsp_cnt;
      #2 rst = 1'b1;
      #1 check("rst_drops_req", 32'(d_req), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(cmd_ready), 1);
      repeat (20) @(negedge clk);
      check("no_rsp_after_rst", 32'(rsp_cnt), 32'(rb));
      check("mem_pre_add", 32'(mem[8'h20]), 32'h40);

      for (int i = 0; i < 40; i++)
         do_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(0, 3)));

      repeat (3) @(negedge clk);
      diff = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
      check("mem_image", 32'(diff), 0);
      check("bus_stable", 32'(stab_err), 0);
      check("rsp_single_pulse", 32'(pulse_err), 0);
      check("ready_only_idle", 32'(rdy_err), 0);
      check("req_gap", 32'(gap_err), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/d_port_master.md
Name: d_port_master

Overview:
- Initiator side of the CPU data-memory port: drives d_req/d_dir/d_addr/d_wdata and consumes d_ack/d_rdata from the data-memory responder.
- Accepts one command at a time from the execute stage: READ, WRITE, or ADD. ADD is a read-modify-write adding a signed delta to a cell, used for the cell increment and decrement instructions.
- Sequences the req/ack handshake, including the mandatory req-low gap between transactions, and adds an ack timeout.

Parameters:
- d_addr_width, 8, width of the data address bus.
- ack_timeout, 16, cycles to wait for d_ack per transaction; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  0=READ, 1=WRITE, 2=ADD, 3=reserved (treated as READ).
- cmd_addr  in  d_addr_width  cell address.
- cmd_wdata  in  8  WRITE data, or ADD delta (two's complement).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  8  READ: value read; WRITE: value written; ADD: new value; on error: 0.
- rsp_err  out  1  valid with rsp_valid; 1 = ack timeout.
- busy  out  1  high in any state other than IDLE.
- d_req  out  1  request to memory.
- d_dir  out  1  direction; uses `DIRECTION_READ`/`DIRECTION_WRITE` encodings.
- d_addr  out  d_addr_width  memory address.
- d_wdata  out  8  write data.
- d_ack  in  1  responder ack.
- d_rdata  in  8  read data; valid in any cycle d_ack is high during a read.

Behaviour:
- Reset: async, active high. All outputs are registered.
  - state=IDLE; d_req=0; d_dir=`DIRECTION_READ`; d_addr=0; d_wdata=0.
  - rsp_valid=0; rsp_data=0; rsp_err=0; timeout counter=0.
  - Reset mid-transaction drops d_req immediately and emits no response.
- Responder contract: ack rises no earlier than the cycle after req rises. Ack stays high while req is held, including across transactions. The master must therefore deassert d_req for at least one cycle between transactions, and never treats an ack as new unless req was low in the previous cycle.
- States: IDLE, RD, GAP, WR, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch op, address and data; d_addr<=cmd_addr; reset the counter.
  - WRITE -> WR, with d_wdata<=cmd_wdata.
  - READ, ADD or reserved op -> RD.
- RD: d_req=1, d_dir=READ. On the cycle d_ack=1, capture d_rdata.
  - READ -> DONE, with rsp_data=captured value.
  - ADD -> GAP, with d_wdata<=(captured + delta) mod 256. Wraps: 0xFF+1=0x00, 0x00+0xFF=0xFF.
- GAP: d_req=0 for exactly one cycle -> WR.
- WR: d_req=1, d_dir=WRITE, d_wdata stable. On d_ack=1 -> DONE with rsp_data=d_wdata.
- DONE: d_req=0; rsp_valid=1 for one cycle -> IDLE. A new command is accepted at the earliest in the following cycle, so the req-low gap is guaranteed.
- Minimum latency from command accept to rsp_valid:
  - READ and WRITE: 3 cycles (accept edge, req cycle, ack cycle, DONE).
  - ADD: 6 cycles.
- Timeout (ack_timeout>0): the counter increments each cycle in RD or WR with d_ack=0, and clears on entering RD or WR.
  - When the counter reaches ack_timeout: drop d_req, go to DONE with rsp_err=1 and rsp_data=0.
  - An ADD that times out in RD never issues its write.
- d_addr, d_dir and d_wdata are held stable for the whole time d_req is high.
- cmd_valid while busy is ignored; cmd_ready=0.

Decomposition:
- Shared include macros/direction.vh (existing): `DIRECTION_READ`/`DIRECTION_WRITE`.
- New shared include macros/d_op.vh: `D_OP_READ`=2'd0, `D_OP_WRITE`=2'd1, `D_OP_ADD`=2'd2, plus state encodings.
- No sub-module required. The 8-bit add is inline; the timeout counter may be split out as d_port_timeout if reused elsewhere.

Test Plan:
- Write then read: WRITE addr 0x05 data 0x3C, then READ 0x05 -> rsp_data=0x3C with rsp_err=0; d_req low for ≥1 cycle between the two transactions; READ latency=3 cycles.
- ADD with wrap: cell 0x10 holds 0xFF; ADD delta 0x01 -> rsp_data=0x00, memory holds 0x00. Then ADD delta 0xFF -> rsp_data=0xFF. Bench checks the exact RD/GAP/WR req pattern: 1,0,1.
- Back-to-back: cmd_valid held high with 4 READs to 0..3 -> each response is correct, d_req never stays high across a transaction boundary, and cmd_ready is high only in IDLE.
- Timeout: responder never acks, ack_timeout=16 -> rsp_valid with rsp_err=1 and rsp_data=0 after 16 RD cycles; no write is issued for an ADD. With ack_timeout=0 the master waits indefinitely.
- Reset mid-ADD: assert rst during WR -> d_req=0 in the same cycle (async), no rsp_valid, cmd_ready=1 after release; memory keeps its pre-ADD value or the written value only if ack already occurred.
- Delayed ack: responder acks 5 cycles after req -> d_addr, d_dir and d_wdata are stable throughout, rsp_data is correct, and rsp_valid is a single-cycle pulse.
